// File: rtl/fwd_lookup_pkg.sv
// ----------------------------------------------------------------------------
// fwd_lookup_pkg
// Shared types and constants for the forwarding lookup engine.
//   fwd_state_t : requester FSM states
//   fwd_kind_t  : forwarding decision kind reported with each egress mask
//   MAC_IG_BIT  : individual/group bit position in a 48-bit MAC
// ----------------------------------------------------------------------------
package fwd_lookup_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESULT
   } fwd_state_t;

   typedef enum logic [1:0] {
      FWD_UNICAST,
      FWD_FLOOD,
      FWD_DROP
   } fwd_kind_t;

   localparam int unsigned MAC_IG_BIT = 40;

endpackage

// File: rtl/sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
// Statistics counter that increments by one per inc_i pulse and sticks at its
// maximum value instead of wrapping.
//   clk     : clock
//   rst     : synchronous reset, active-high, clears the count
//   inc_i   : increment request
//   count_o : current count
// ----------------------------------------------------------------------------
module sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc_i,
   output logic [CNT_W-1:0] count_o
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (inc_i && (r_count != '1)) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign count_o = r_count;

endmodule

// File: rtl/fwd_lookup_engine.sv
// ----------------------------------------------------------------------------
// fwd_lookup_engine
// Requester side of the MAC address table. Takes one parsed header per
// handshake, issues a learn request for the source and a read request for the
// destination, then turns the table answer into a unicast / flood / drop
// decision expressed as an egress port mask.
//   clk, rst            : clock, synchronous active-high reset
//   hdr_*               : header descriptor in (valid/ready handshake)
//   learn_*             : learn request to the address table (1-cycle pulse)
//   read_req_o/address  : lookup request to the address table (1-cycle pulse)
//   read_port_*         : lookup response from the address table
//   fwd_*               : forwarding decision out (valid/ready handshake)
//   stat_*_o            : saturating hit / flood / drop counters
// ----------------------------------------------------------------------------
module fwd_lookup_engine
   import fwd_lookup_pkg::*;
#(
   parameter  int unsigned NUM_PORTS      = 4,
   parameter  int unsigned LOOKUP_TIMEOUT = 8,
   parameter  int unsigned CNT_W          = 16,
   localparam int unsigned PW             = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 hdr_valid_i,
   output logic                 hdr_ready_o,
   input  logic [47:0]          hdr_dst_mac_i,
   input  logic [47:0]          hdr_src_mac_i,
   input  logic [PW-1:0]        hdr_ingress_i,
   output logic                 learn_req_o,
   output logic [47:0]          learn_address_o,
   output logic [PW-1:0]        learn_port_o,
   output logic                 read_req_o,
   output logic [47:0]          read_address_o,
   input  logic [PW-1:0]        read_port_i,
   input  logic                 read_port_valid_i,
   output logic                 fwd_valid_o,
   input  logic                 fwd_ready_i,
   output logic [NUM_PORTS-1:0] fwd_mask_o,
   output fwd_kind_t            fwd_kind_o,
   output logic [CNT_W-1:0]     stat_hit_o,
   output logic [CNT_W-1:0]     stat_flood_o,
   output logic [CNT_W-1:0]     stat_drop_o
);

   localparam int unsigned TW = $clog2(LOOKUP_TIMEOUT) + 1;

   fwd_state_t           r_state;
   logic [47:0]          r_dst;
   logic [47:0]          r_src;
   logic [PW-1:0]        r_ingress;
   logic                 r_learn_req;
   logic                 r_read_req;
   logic [TW-1:0]        r_timer;
   logic                 r_fwd_valid;
   logic [NUM_PORTS-1:0] r_mask;
   fwd_kind_t            r_kind;

   logic                 w_src_learnable;
   logic [NUM_PORTS-1:0] w_flood_mask;
   logic [NUM_PORTS-1:0] w_hit_mask;
   fwd_kind_t            w_hit_kind;
   logic                 w_accept;

   // Group-addressed or all-zero sources are never installed in the table.
   assign w_src_learnable = ~hdr_src_mac_i[MAC_IG_BIT] && (hdr_src_mac_i != '0);

   // Flood goes everywhere except back out of the ingress port.
   always_comb begin
      w_flood_mask = '1;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         if (32'(r_ingress) == i) begin
            w_flood_mask[i] = 1'b0;
         end
      end
   end

   // Decision for a table hit; an out-of-range port is treated like a miss.
   always_comb begin
      w_hit_kind = FWD_UNICAST;
      w_hit_mask = '0;
      if (32'(read_port_i) >= NUM_PORTS) begin
         w_hit_kind = FWD_FLOOD;
         w_hit_mask = w_flood_mask;
      end else if (read_port_i == r_ingress) begin
         w_hit_kind = FWD_DROP;
      end else begin
         for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            w_hit_mask[i] = (32'(read_port_i) == i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_dst       <= '0;
         r_src       <= '0;
         r_ingress   <= '0;
         r_learn_req <= 1'b0;
         r_read_req  <= 1'b0;
         r_timer     <= '0;
         r_fwd_valid <= 1'b0;
         r_mask      <= '0;
         r_kind      <= FWD_UNICAST;
      end else begin
         // Request strobes are only ever high for the single ISSUE cycle.
         r_learn_req <= 1'b0;
         r_read_req  <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (hdr_valid_i) begin
                  r_dst       <= hdr_dst_mac_i;
                  r_src       <= hdr_src_mac_i;
                  r_ingress   <= hdr_ingress_i;
                  r_learn_req <= w_src_learnable;
                  r_read_req  <= ~hdr_dst_mac_i[MAC_IG_BIT];
                  r_state     <= ISSUE;
               end
            end
            ISSUE: begin
               if (!r_dst[MAC_IG_BIT]) begin
                  r_timer <= '0;
                  r_state <= WAIT;
               end else begin
                  // Multicast/broadcast needs no lookup.
                  r_fwd_valid <= 1'b1;
                  r_kind      <= FWD_FLOOD;
                  r_mask      <= w_flood_mask;
                  r_state     <= RESULT;
               end
            end
            WAIT: begin
               if (read_port_valid_i) begin
                  r_fwd_valid <= 1'b1;
                  r_kind      <= w_hit_kind;
                  r_mask      <= w_hit_mask;
                  r_state     <= RESULT;
               end else if (r_timer == TW'(LOOKUP_TIMEOUT - 1)) begin
                  r_fwd_valid <= 1'b1;
                  r_kind      <= FWD_FLOOD;
                  r_mask      <= w_flood_mask;
                  r_state     <= RESULT;
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            end
            RESULT: begin
               if (fwd_ready_i) begin
                  r_fwd_valid <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign w_accept = (r_state == RESULT) && fwd_ready_i;

   sat_counter #(.CNT_W(CNT_W)) u_stat_hit (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (w_accept && (r_kind == FWD_UNICAST)),
      .count_o (stat_hit_o)
   );

   sat_counter #(.CNT_W(CNT_W)) u_stat_flood (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (w_accept && (r_kind == FWD_FLOOD)),
      .count_o (stat_flood_o)
   );

   sat_counter #(.CNT_W(CNT_W)) u_stat_drop (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (w_accept && (r_kind == FWD_DROP)),
      .count_o (stat_drop_o)
   );

   assign hdr_ready_o     = (r_state == IDLE);
   assign learn_req_o     = r_learn_req;
   assign learn_address_o = r_src;
   assign learn_port_o    = r_ingress;
   assign read_req_o      = r_read_req;
   assign read_address_o  = r_dst;
   assign fwd_valid_o     = r_fwd_valid;
   assign fwd_mask_o      = r_mask;
   assign fwd_kind_o      = r_kind;

endmodule
